// File: rtl/exe_stage_md_if.sv
// Handshake and data bus between decode, the execute stage and the memory stage.
// The stage itself connects through the slave modport; whoever drives decode/memory uses master.
interface exe_stage_md_if #(
    parameter int XLEN = 32
);
    // decode -> execute
    logic            ds_to_es_valid;
    logic [3:0]      ds_op;
    logic [XLEN-1:0] ds_src1;
    logic [XLEN-1:0] ds_src2;
    logic            ds_gr_we;
    logic [4:0]      ds_dest;
    logic [XLEN-1:0] ds_pc;
    logic            es_allowin;
    // control
    logic            es_flush;
    // execute -> memory
    logic            ms_allowin;
    logic            es_to_ms_valid;
    logic [XLEN-1:0] es_result;
    logic            es_gr_we_o;
    logic [4:0]      es_dest_o;
    logic [XLEN-1:0] es_pc_o;
    // hazard / forwarding back to decode
    logic [7:0]      es_hazard_bus;
    logic [XLEN-1:0] es_forward;

    modport slave (
        input  ds_to_es_valid, ds_op, ds_src1, ds_src2, ds_gr_we, ds_dest, ds_pc,
        input  es_flush, ms_allowin,
        output es_allowin, es_to_ms_valid, es_result, es_gr_we_o, es_dest_o, es_pc_o,
        output es_hazard_bus, es_forward
    );

    modport master (
        output ds_to_es_valid, ds_op, ds_src1, ds_src2, ds_gr_we, ds_dest, ds_pc,
        output es_flush, ms_allowin,
        input  es_allowin, es_to_ms_valid, es_result, es_gr_we_o, es_dest_o, es_pc_o,
        input  es_hazard_bus, es_forward
    );
endinterface

// File: rtl/exe_stage_md.sv
// Execute stage with ADD/SUB, a fixed-latency multiplier and a restoring radix-2 divider.
// ready_go comes from a small FSM; the hazard bus flags the stage busy until the result is ready.
module exe_stage_md #(
    parameter int XLEN    = 32,
    parameter int MUL_LAT = 2
) (
    input logic           clk,
    input logic           reset,
    exe_stage_md_if.slave bus
);
    localparam int CNT_W = 7;
    localparam logic [CNT_W-1:0] MUL_LAT_C = CNT_W'(MUL_LAT);
    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(XLEN - 1);

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_SIGN, S_DONE} state_t;

    function automatic logic op_is_mul(input logic [3:0] o);
        return (o >= 4'd2) && (o <= 4'd4);
    endfunction

    function automatic logic op_is_div(input logic [3:0] o);
        return (o >= 4'd5) && (o <= 4'd8);
    endfunction

    function automatic logic op_is_sdiv(input logic [3:0] o);
        return (o == 4'd5) || (o == 4'd6);
    endfunction

    function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v, input logic sgn);
        return (sgn && v[XLEN-1]) ? -v : v;
    endfunction

    // One restoring step: shift the next dividend bit into the partial remainder, subtract if it fits.
    function automatic logic [2*XLEN-1:0] div_step(input logic [XLEN-1:0] r, input logic [XLEN-1:0] q,
                                                   input logic [XLEN-1:0] d);
        logic [XLEN:0] trial;
        trial = {r, q[XLEN-1]};
        if (trial >= {1'b0, d})
            return {trial[XLEN-1:0] - d, q[XLEN-2:0], 1'b1};
        return {trial[XLEN-1:0], q[XLEN-2:0], 1'b0};
    endfunction

    // Sign correction plus the divide-by-zero rule; MIN/-1 falls out of the magnitude arithmetic.
    function automatic logic [XLEN-1:0] div_fix(input logic [3:0] o, input logic [XLEN-1:0] a,
                                                input logic [XLEN-1:0] b, input logic [XLEN-1:0] q,
                                                input logic [XLEN-1:0] r);
        logic [XLEN-1:0] qf;
        logic [XLEN-1:0] rf;
        if (b == '0) begin
            qf = '1;
            rf = a;
        end else if (op_is_sdiv(o)) begin
            qf = (a[XLEN-1] ^ b[XLEN-1]) ? -q : q;
            rf = a[XLEN-1] ? -r : r;
        end else begin
            qf = q;
            rf = r;
        end
        return ((o == 4'd5) || (o == 4'd7)) ? qf : rf;
    endfunction

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             es_valid, valid_nxt;
    logic             ready_go, es_allowin, es_to_ms_valid, cap, leave;

    logic [3:0]       op;
    logic [XLEN-1:0]  src1, src2, pc;
    logic             gr_we;
    logic [4:0]       dest;
    logic [XLEN-1:0]  quo, rem, dvsr, div_res;
    logic [XLEN-1:0]  result, mulhu;
    logic signed [2*XLEN-1:0] prod_s;

    // ready_go per operation class: simple ops at once, multi-cycle ops when their FSM says so
    always_comb begin
        ready_go = 1'b1;
        if (op_is_mul(op))
            ready_go = (state == S_MUL) && (cnt == MUL_LAT_C);
        else if (op_is_div(op))
            ready_go = (state == S_DONE);
    end

    assign es_allowin     = !es_valid || (ready_go && bus.ms_allowin);
    assign es_to_ms_valid = es_valid && ready_go;
    assign cap            = bus.ds_to_es_valid && es_allowin && !bus.es_flush;
    assign leave          = es_to_ms_valid && bus.ms_allowin;

    // Control state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            es_valid <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            es_valid <= valid_nxt;
        end
    end

    // Next-state logic: flush beats capture, capture beats leaving, otherwise advance the sequence
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        valid_nxt = es_valid;
        if (bus.es_flush) begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
            valid_nxt = 1'b0;
        end else begin
            if (es_allowin)
                valid_nxt = bus.ds_to_es_valid;
            if (cap) begin
                cnt_nxt   = '0;
                state_nxt = op_is_mul(bus.ds_op) ? S_MUL :
                            op_is_div(bus.ds_op) ? S_DIV : S_IDLE;
            end else if (leave) begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end else begin
                case (state)
                    S_MUL:   if (cnt != MUL_LAT_C) cnt_nxt = cnt + 1'b1;
                    S_DIV: begin
                        cnt_nxt = cnt + 1'b1;
                        if (cnt == DIV_LAST) state_nxt = S_SIGN;
                    end
                    S_SIGN:  state_nxt = S_DONE;
                    default: ;
                endcase
            end
        end
    end

    // Operand capture and divider datapath
    always_ff @(posedge clk) begin
        if (reset) begin
            op      <= '0;
            src1    <= '0;
            src2    <= '0;
            pc      <= '0;
            gr_we   <= 1'b0;
            dest    <= '0;
            quo     <= '0;
            rem     <= '0;
            dvsr    <= '0;
            div_res <= '0;
        end else if (cap) begin
            op    <= bus.ds_op;
            src1  <= bus.ds_src1;
            src2  <= bus.ds_src2;
            pc    <= bus.ds_pc;
            gr_we <= bus.ds_gr_we;
            dest  <= bus.ds_dest;
            quo   <= magnitude(bus.ds_src1, op_is_sdiv(bus.ds_op));
            dvsr  <= magnitude(bus.ds_src2, op_is_sdiv(bus.ds_op));
            rem   <= '0;
        end else if (state == S_DIV) begin
            {rem, quo} <= div_step(rem, quo, dvsr);
        end else if (state == S_SIGN) begin
            div_res <= div_fix(op, src1, src2, quo, rem);
        end
    end

    // Single signed multiplier; the unsigned high half is recovered from it with two add-backs
    assign prod_s = $signed({{XLEN{src1[XLEN-1]}}, src1}) * $signed({{XLEN{src2[XLEN-1]}}, src2});
    assign mulhu  = prod_s[2*XLEN-1:XLEN] + (src1[XLEN-1] ? src2 : '0) + (src2[XLEN-1] ? src1 : '0);

    // Result select
    always_comb begin
        case (op)
            4'd1:                   result = src1 - src2;
            4'd2:                   result = prod_s[XLEN-1:0];
            4'd3:                   result = prod_s[2*XLEN-1:XLEN];
            4'd4:                   result = mulhu;
            4'd5, 4'd6, 4'd7, 4'd8: result = div_res;
            default:                result = src1 + src2;
        endcase
    end

    assign bus.es_allowin     = es_allowin;
    assign bus.es_to_ms_valid = es_to_ms_valid;
    assign bus.es_result      = result;
    assign bus.es_forward     = result;
    assign bus.es_gr_we_o     = gr_we;
    assign bus.es_dest_o      = dest;
    assign bus.es_pc_o        = pc;
    assign bus.es_hazard_bus  = {es_valid && !ready_go, es_valid, gr_we, dest};
endmodule

// File: tb/tb_exe_stage_md.sv
// Bench for exe_stage_md: vector table plus random ops through a result scoreboard,
// and hand-written sequences for back-to-back, backpressure, flush and reset.
module tb_exe_stage_md;
    localparam int XLEN    = 32;
    localparam int MUL_LAT = 2;
    localparam int DIV_LAT = XLEN + 1;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  dest;
        logic [31:0] pc;
        logic        gr_we;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    exe_stage_md_if #(.XLEN(XLEN)) bus ();
    exe_stage_md #(.XLEN(XLEN), .MUL_LAT(MUL_LAT)) dut (.clk(clk), .reset(reset), .bus(bus));

    exp_t        scb[$];
    vec_t        vt[$];
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] pc_ctr   = 32'h1000;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic int lat_of(input logic [3:0] op);
        if (op >= 4'd2 && op <= 4'd4) return MUL_LAT;
        if (op >= 4'd5 && op <= 4'd8) return DIV_LAT;
        return 0;
    endfunction

    function automatic logic [31:0] ref_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sx, sy, sp;
        longint unsigned ux, uy, up;
        int              ia, ib;
        sx = longint'($signed(a));
        sy = longint'($signed(b));
        sp = sx * sy;
        ux = {32'd0, a};
        uy = {32'd0, b};
        up = ux * uy;
        ia = $signed(a);
        ib = $signed(b);
        case (op)
            4'd1: return a - b;
            4'd2: return up[31:0];
            4'd3: return sp[63:32];
            4'd4: return up[63:32];
            4'd5: return (b == 0) ? 32'hFFFF_FFFF : (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? a : 32'(ia / ib);
            4'd6: return (b == 0) ? a : (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'd0 : 32'(ia % ib);
            4'd7: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            4'd8: return (b == 0) ? a : a % b;
            default: return a + b;
        endcase
    endfunction

    // Scoreboard: every instruction leaving the stage must match the oldest expectation
    always @(negedge clk) begin
        exp_t e;
        if (!reset && bus.es_to_ms_valid && bus.ms_allowin) begin
            if (scb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output actual=%h required=no_output", bus.es_result);
            end else begin
                e = scb.pop_front();
                chk("result", bus.es_result, e.res);
                chk("forward", bus.es_forward, e.res);
                chk("dest", bus.es_dest_o, e.dest);
                chk("pc", bus.es_pc_o, e.pc);
                chk("gr_we", bus.es_gr_we_o, e.gr_we);
            end
        end
    end

    // Present one instruction (called just after a rising edge); returns just after its capture edge
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, output int waited);
        waited = 0;
        bus.ds_to_es_valid = 1'b1;
        bus.ds_op   = op;
        bus.ds_src1 = a;
        bus.ds_src2 = b;
        bus.ds_pc   = pc_ctr;
        bus.ds_dest = pc_ctr[6:2];
        bus.ds_gr_we = pc_ctr[2];
        @(negedge clk);
        while (!bus.es_allowin && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.es_allowin) begin
            checks++;
            failures++;
            $display("FAIL issue_timeout actual=allowin_low required=allowin_high");
        end else begin
            scb.push_back('{exp, pc_ctr[6:2], pc_ctr, pc_ctr[2]});
        end
        @(posedge clk);
        #1;
        bus.ds_to_es_valid = 1'b0;
        pc_ctr = pc_ctr + 32'd4;
    endtask

    // Issue, then follow the instruction cycle by cycle until it leaves
    task automatic run_vec(input vec_t v);
        int  c;
        int  w;
        bit  bad;
        bit  found;
        c = 0;
        bad = 1'b0;
        found = 1'b0;
        issue(v.op, v.a, v.b, v.exp, w);
        while (c < 100 && !found) begin
            @(negedge clk);
            if (bus.es_to_ms_valid) found = 1'b1;
            else begin
                if (!bus.es_hazard_bus[7] || bus.es_allowin) bad = 1'b1;
                c++;
            end
        end
        if (!found) begin
            checks++;
            failures++;
            $display("FAIL latency_timeout op=%0d actual=none required=%0d", v.op, v.lat);
        end else begin
            chk("latency", c, v.lat);
            chk("busy_before_ready", bad, 0);
            chk("busy_at_ready", bus.es_hazard_bus[7], 0);
            chk("allowin_at_ready", bus.es_allowin, 1);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   w;
        int   c;
        bit   bad;
        vec_t v;
        vt.push_back('{4'd0,  32'd5,          32'd7,          32'd12,         0});
        vt.push_back('{4'd1,  32'd3,          32'd5,          32'hFFFF_FFFE,  0});
        vt.push_back('{4'd12, 32'd1,          32'd2,          32'd3,          0});
        vt.push_back('{4'd3,  32'h8000_0000,  32'h8000_0000,  32'h4000_0000,  MUL_LAT});
        vt.push_back('{4'd4,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  MUL_LAT});
        vt.push_back('{4'd2,  32'd6,          32'd7,          32'd42,         MUL_LAT});
        vt.push_back('{4'd5,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  DIV_LAT});
        vt.push_back('{4'd6,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  DIV_LAT});
        vt.push_back('{4'd7,  32'd10,         32'd0,          32'hFFFF_FFFF,  DIV_LAT});
        vt.push_back('{4'd8,  32'd10,         32'd0,          32'd10,         DIV_LAT});
        vt.push_back('{4'd5,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  DIV_LAT});
        vt.push_back('{4'd6,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          DIV_LAT});
        vt.push_back('{4'd5,  32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFFF,  DIV_LAT});
        vt.push_back('{4'd6,  32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFF9,  DIV_LAT});
        vt.push_back('{4'd7,  32'd100,        32'd7,          32'd14,         DIV_LAT});
        vt.push_back('{4'd8,  32'd100,        32'd7,          32'd2,          DIV_LAT});

        reset = 1'b1;
        bus.ds_to_es_valid = 1'b0;
        bus.ds_op = '0;
        bus.ds_src1 = '0;
        bus.ds_src2 = '0;
        bus.ds_gr_we = 1'b0;
        bus.ds_dest = '0;
        bus.ds_pc = '0;
        bus.es_flush = 1'b0;
        bus.ms_allowin = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_to_ms_valid", bus.es_to_ms_valid, 0);
        chk("reset_allowin", bus.es_allowin, 1);
        chk("reset_result", bus.es_result, 0);
        chk("reset_hazard_bus", bus.es_hazard_bus, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        foreach (vt[i]) run_vec(vt[i]);

        for (int i = 0; i < 10; i++) begin
            v.op  = 4'($urandom_range(0, 8));
            v.a   = $urandom;
            v.b   = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
            v.exp = ref_fn(v.op, v.a, v.b);
            v.lat = lat_of(v.op);
            run_vec(v);
        end

        // back-to-back ADD then SUB with no bubble
        issue(4'd0, 32'd5, 32'd7, 32'd12, w);
        issue(4'd1, 32'd3, 32'd5, 32'hFFFF_FFFE, w);
        chk("b2b_no_wait", w, 0);
        @(negedge clk);
        chk("b2b_valid", bus.es_to_ms_valid, 1);
        @(posedge clk);
        #1;

        // result held stable under memory-stage backpressure, then the next ADD follows at once
        bus.ms_allowin = 1'b0;
        issue(4'd7, 32'd100, 32'd7, 32'd14, w);
        c = 0;
        @(negedge clk);
        while (!bus.es_to_ms_valid && c < 100) begin
            @(negedge clk);
            c++;
        end
        chk("hold_latency", c, DIV_LAT);
        bad = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (!bus.es_to_ms_valid || bus.es_result !== 32'd14 || bus.es_allowin) bad = 1'b1;
        end
        chk("hold_stable", bad, 0);
        @(posedge clk);
        #1;
        bus.ms_allowin = 1'b1;
        issue(4'd0, 32'd1, 32'd2, 32'd3, w);
        chk("hold_next_no_wait", w, 0);
        @(negedge clk);
        chk("hold_next_valid", bus.es_to_ms_valid, 1);
        @(posedge clk);
        #1;

        // flush, then reset, in cycle 10 of a divide while decode presents a new op
        for (int pass = 0; pass < 2; pass++) begin
            issue(4'd5, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, w);
            repeat (10) @(posedge clk);
            #1;
            if (pass == 0) bus.es_flush = 1'b1;
            else reset = 1'b1;
            bus.ds_to_es_valid = 1'b1;
            bus.ds_op = 4'd0;
            bus.ds_src1 = 32'd9;
            bus.ds_src2 = 32'd9;
            @(negedge clk);
            chk("kill_pre_busy", bus.es_hazard_bus[7], 1);
            @(posedge clk);
            #1;
            bus.es_flush = 1'b0;
            reset = 1'b0;
            bus.ds_to_es_valid = 1'b0;
            void'(scb.pop_back());
            @(negedge clk);
            chk("kill_to_ms_valid", bus.es_to_ms_valid, 0);
            chk("kill_allowin", bus.es_allowin, 1);
            chk("kill_valid_busy", bus.es_hazard_bus[7:6], 0);
            if (pass == 1) begin
                chk("kill_reset_bus", bus.es_hazard_bus, 0);
                chk("kill_reset_result", bus.es_result, 0);
            end
            @(posedge clk);
            #1;
            run_vec('{4'd0, 32'd1, 32'd1, 32'd2, 0});
            run_vec('{4'd7, 32'd100, 32'd7, 32'd14, DIV_LAT});
        end

        repeat (3) @(posedge clk);
        chk("scoreboard_empty", scb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
